// File: rtl/sat_accum_pkg.sv
// Shared types and constants for the saturating burst accumulator.
package sat_accum_pkg;

  // Burst sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Legal one-hot selector values and the code each one maps to.
  localparam logic [3:0] SEL_CODE3 = 4'b0001;
  localparam logic [3:0] SEL_CODE2 = 4'b0010;
  localparam logic [3:0] SEL_CODE1 = 4'b0100;
  localparam logic [3:0] SEL_CODE0 = 4'b1000;

endpackage

// File: rtl/onehot2_encoder.sv
// Maps a 4-bit one-hot selector onto a 2-bit code.
// Any value that is not one of the four legal one-hot patterns yields code 0
// and raises err.
module onehot2_encoder
  import sat_accum_pkg::*;
(
  input  logic [3:0] sel,
  output logic [1:0] code,
  output logic       err
);

  // Full-case decode with an explicit fallback for illegal selectors.
  always_comb begin
    code = 2'd0;
    err  = 1'b0;
    case (sel)
      SEL_CODE3: code = 2'd3;
      SEL_CODE2: code = 2'd2;
      SEL_CODE1: code = 2'd1;
      SEL_CODE0: code = 2'd0;
      default: begin
        code = 2'd0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sat_accum_encoder.sv
// Accumulates BURST_LEN beats into a saturating sum, encodes the selector of
// the final beat and presents the result until downstream takes it.
//
// Handshakes: a beat transfers on a rising clk edge where in_valid && in_ready;
// a result transfers on an edge where out_valid && out_ready. in_ready is low
// while a result is held, so no beat is taken in that cycle, and the result
// fields stay frozen until the transfer.
module sat_accum_encoder
  import sat_accum_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 9,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [1:0]        out_code,
  output logic              out_sat,
  output logic              out_err,
  output state_t            state_dbg
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [CNT_W-1:0]  beat_cnt, cnt_nxt;
  logic              sat, sat_nxt;
  logic              err, err_nxt;
  logic [1:0]        code, code_nxt;

  logic [1:0]        enc_code;
  logic              enc_err;
  logic [ACC_W:0]    sum_ext;
  logic              accept;

  onehot2_encoder u_enc (
    .sel  (in_sel),
    .code (enc_code),
    .err  (enc_err)
  );

  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;

  // One guard bit above the accumulator catches overflow of the add.
  assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(in_data);

  // Next-state and datapath update; every register holds unless changed.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = beat_cnt;
    sat_nxt   = sat;
    err_nxt   = err;
    code_nxt  = code;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = ACC_W'(in_data);
          cnt_nxt   = CNT_W'(1);
          sat_nxt   = 1'b0;
          err_nxt   = enc_err;
          code_nxt  = enc_code;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (sum_ext[ACC_W]) begin
            acc_nxt = ACC_MAX;
            sat_nxt = 1'b1;
          end else begin
            acc_nxt = sum_ext[ACC_W-1:0];
          end
          cnt_nxt  = beat_cnt + CNT_W'(1);
          err_nxt  = err | enc_err;
          code_nxt = enc_code;
          if (beat_cnt == LAST_IDX) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          sat_nxt   = 1'b0;
          err_nxt   = 1'b0;
          code_nxt  = 2'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      beat_cnt <= '0;
      sat      <= 1'b0;
      err      <= 1'b0;
      code     <= 2'd0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      beat_cnt <= cnt_nxt;
      sat      <= sat_nxt;
      err      <= err_nxt;
      code     <= code_nxt;
    end
  end

  assign out_valid = (state == HOLD);
  assign out_sum   = acc;
  assign out_code  = code;
  assign out_sat   = sat;
  assign out_err   = err;
  assign state_dbg = state;

endmodule

// File: tb/tb_sat_accum_encoder.sv
// Directed and randomized bench for sat_accum_encoder with a burst-level
// reference model and an expected-result queue.
module tb_sat_accum_encoder;
  import sat_accum_pkg::*;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int BL = 4;
  localparam int ACC_MAX = (1 << AW) - 1;
  localparam int RW = AW + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [3:0]    in_sel;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [1:0]    out_code;
  logic          out_sat;
  logic          out_err;
  state_t        state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] bd[BL];
  logic [3:0]    bs[BL];
  int            bg[BL];
  logic [RW-1:0] exp_q[$];

  sat_accum_encoder #(
    .DATA_W    (DW),
    .ACC_W     (AW),
    .BURST_LEN (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_code  (out_code),
    .out_sat   (out_sat),
    .out_err   (out_err),
    .state_dbg (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Selector code from the rule: a single set bit at position b gives 3-b.
  function automatic logic [1:0] code_of(input logic [3:0] s);
    if ($countones(s) != 1) return 2'd0;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) return 2'(3 - b);
    end
    return 2'd0;
  endfunction

  // Burst result from plain arithmetic: total clamped, sat if total overflowed.
  function automatic logic [RW-1:0] model_burst();
    int            total = 0;
    logic          e = 1'b0;
    logic [AW-1:0] sum;
    logic          s;
    for (int i = 0; i < BL; i++) begin
      total += int'(bd[i]);
      if ($countones(bs[i]) != 1) e = 1'b1;
    end
    s   = (total > ACC_MAX);
    sum = s ? AW'(ACC_MAX) : AW'(total);
    return {sum, code_of(bs[BL-1]), s, e};
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", state_dbg, IDLE);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sum", out_sum, 0);
    check("reset_out_code", out_code, 0);
    check("reset_flags", {out_sat, out_err}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Present one beat and wait (bounded) for it to transfer.
  task automatic send_beat(input logic [DW-1:0] d, input logic [3:0] s);
    bit done = 1'b0;
    in_valid = 1'b1; in_data = d; in_sel = s;
    for (int t = 0; t < 20 && !done; t++) begin
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL beat_accept_timeout observed=0 expected=1");
    end
  endtask

  // Run one full burst from bd/bs/bg, hold the result for hold cycles with
  // in_valid asserted, then release it with a simultaneous beat offered.
  task automatic run_burst(input int hold);
    logic [RW-1:0] expv;
    exp_q.push_back(model_burst());
    out_ready = 1'b0;
    for (int i = 0; i < BL; i++) begin
      for (int g = 0; g < bg[i]; g++) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("gap_out_valid", out_valid, 0);
      end
      check("pre_beat_out_valid", out_valid, 0);
      send_beat(bd[i], bs[i]);
    end
    expv = exp_q.pop_front();
    check("latency_out_valid", out_valid, 1);
    check("hold_in_ready", in_ready, 0);
    check("result", {out_sum, out_code, out_sat, out_err}, expv);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom_range(1, 255));
      in_sel   = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready_stall", in_ready, 0);
      check("hold_stable", {out_sum, out_code, out_sat, out_err}, expv);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = DW'($urandom_range(1, 255));
    in_sel    = 4'b0001;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_no_accept", {out_sum, out_code, out_sat, out_err}, 0);
  endtask

  task automatic set_burst(input logic [DW-1:0] d0, d1, d2, d3,
                           input logic [3:0] s0, s1, s2, s3,
                           input int g0, g1, g2, g3);
    bd[0] = d0; bd[1] = d1; bd[2] = d2; bd[3] = d3;
    bs[0] = s0; bs[1] = s1; bs[2] = s2; bs[3] = s3;
    bg[0] = g0; bg[1] = g1; bg[2] = g2; bg[3] = g3;
  endtask

  // Directed steps followed by randomized bursts.
  initial begin
    do_reset();

    // Plain sum, code 3.
    set_burst(10, 20, 30, 40, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 0);
    run_burst(0);

    // Saturation.
    set_burst(255, 255, 255, 255, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 0, 0, 0, 0);
    run_burst(1);

    // Illegal selector on beat 3 makes err sticky.
    set_burst(1, 2, 3, 4, 4'b1000, 4'b1000, 4'b0011, 4'b1000, 0, 0, 0, 0);
    run_burst(0);

    // Illegal selector on the last beat gives code 0.
    set_burst(7, 7, 7, 7, 4'b0100, 4'b0100, 4'b0100, 4'b0011, 0, 0, 0, 0);
    run_burst(0);

    // Backpressure for 5 cycles with in_valid high.
    set_burst(9, 9, 9, 9, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 0, 0, 0, 0);
    run_burst(5);

    // Reset after two beats discards the partial burst.
    send_beat(50, 4'b0001);
    send_beat(60, 4'b0011);
    check("partial_sum", out_sum, 110);
    check("partial_err", out_err, 1);
    check("partial_no_valid", out_valid, 0);
    rst = 1'b1;
    #1;
    check("async_rst_state", state_dbg, IDLE);
    check("async_rst_regs", {out_valid, out_sum, out_code, out_sat, out_err}, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_burst(1, 1, 1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 0);
    run_burst(0);

    // Gapped in_valid pattern 1,0,0,1,1,0,1.
    set_burst(5, 6, 7, 8, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 0, 2, 0, 1);
    run_burst(0);

    // Randomized bursts.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < BL; i++) begin
        bd[i] = DW'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) bs[i] = 4'(4'b0001 << $urandom_range(0, 3));
        else bs[i] = 4'($urandom_range(0, 15));
        bg[i] = $urandom_range(0, 2);
      end
      run_burst($urandom_range(0, 3));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sat_accum_encoder.md
SAT_ACCUM_ENCODER -- requirements
Module: sat_accum_encoder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning input data width.
REQ-002 The block SHALL have parameter ACC_W, default 9, meaning accumulator/output sum width (ACC_W >= DATA_W).
REQ-003 The block SHALL have parameter BURST_LEN, default 4, meaning beats per accumulation burst (>= 2).
REQ-004 The block SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1, upstream beat valid.
REQ-007 The block SHALL have port in_ready, output, 1, block can accept a beat.
REQ-008 The block SHALL have port in_data, input, DATA_W, unsigned beat value.
REQ-009 The block SHALL have port in_sel, input, 4, one-hot selector accompanying the beat.
REQ-010 The block SHALL have port out_valid, output, 1, burst result valid.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts result.
REQ-012 The block SHALL have port out_sum, output, ACC_W, saturated burst sum.
REQ-013 The block SHALL have port out_code, output, 2, encoded selector of last beat.
REQ-014 The block SHALL have ports out_sat and out_err, outputs, 1 each: saturation occurred / non-one-hot selector seen in burst.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM, HOLD; reset state IDLE.
REQ-016 A beat SHALL be accepted only in a cycle with in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD.
REQ-017 IDLE: accepted beat loads acc = in_data, beat_cnt = 1, moves to ACCUM; no beat, stay.
REQ-018 ACCUM: each accepted beat adds in_data to acc, increments beat_cnt; the BURST_LEN-th beat moves to HOLD.
REQ-019 The add SHALL be computed at ACC_W+1 bits; if the result exceeds 2^ACC_W-1, acc SHALL clamp to 2^ACC_W-1 and sat flag set, sticky for the burst.
REQ-020 in_sel encoding SHALL be 0001->3, 0010->2, 0100->1, 1000->0; any other value -> code 0 and err flag set, sticky for the burst.
REQ-021 out_code SHALL reflect the last accepted beat of the burst.
REQ-022 out_valid SHALL be 1 exactly in HOLD, first asserted the cycle after the final beat is accepted (latency 1).
REQ-023 out_sum/out_code/out_sat/out_err SHALL be stable while out_valid && !out_ready.
REQ-024 HOLD with out_ready=1 SHALL return to IDLE and clear acc, beat_cnt, sat, err next cycle; a simultaneous in_valid is not accepted.
REQ-025 in_valid low in ACCUM SHALL stall without changing state.

Reset
REQ-026 rst SHALL force state IDLE, acc 0, beat_cnt 0, sat 0, err 0, out_valid 0, out_sum 0, out_code 0, in_ready 1 immediately and asynchronously.
REQ-027 rst mid-burst SHALL discard the partial burst; no result is emitted for it.

Structure
REQ-028 State enum and the four one-hot selector constants SHALL live in shared package sat_accum_pkg.
REQ-029 Selector encoding SHALL be a sub-module onehot2_encoder (purely combinational, full case with default).
REQ-030 beat_cnt width SHALL be $clog2(BURST_LEN+1).

Verification
REQ-031 Beats 10,20,30,40, sel 0001 -> out_sum 100, code 3, sat 0, err 0, out_valid one cycle after 4th beat.
REQ-032 Beats 255 x4 -> out_sum 511, sat 1.
REQ-033 Beat 3 sel 0011, others sel 1000 -> err 1; last beat sel 0011 -> code 0.
REQ-034 Hold out_ready 0 for 5 cycles in HOLD with in_valid 1 -> in_ready 0, outputs stable, no beat consumed.
REQ-035 rst after 2 beats, then beats 1,1,1,1 -> out_sum 4, sat 0, err 0.
REQ-036 Gapped in_valid (1,0,0,1,1,0,1) -> single result after 4th accepted beat, correct sum.
